rf_wb_arbiter: RTL and testbench



---
 rtl/rf_ctrl_pkg.sv | 11 +
 rtl/rf_scoreboard.sv | 36 +++
 rtl/rf_wb_arbiter.sv | 93 +++++++++
 tb/tb_rf_wb_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write-port control slice.
package rf_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic {SRC_P, SRC_M} wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for long-latency destinations and the decode stall lookup.
module rf_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      sb_set,
  input  reg_addr_t sb_rd,
  input  logic      clr_en,
  input  reg_addr_t clr_rd,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  output logic      stall
);

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;

  // Clear is applied before set so a same-cycle re-issue keeps the register pending.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[clr_rd] = 1'b0;
    if (sb_set && (sb_rd != '0)) pend_nxt[sb_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  assign stall = pend[rs1] | pend[rs2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and the long-latency unit.
module rf_wb_arbiter
  import rf_ctrl_pkg::reg_addr_t;
  import rf_ctrl_pkg::wb_src_e;
  import rf_ctrl_pkg::SRC_P;
  import rf_ctrl_pkg::SRC_M;
#(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p_valid,
  output logic            p_ready,
  input  reg_addr_t       p_rd,
  input  logic [XLEN-1:0] p_data,
  input  logic            m_valid,
  output logic            m_ready,
  input  reg_addr_t       m_rd,
  input  logic [XLEN-1:0] m_data,
  input  logic            sb_set,
  input  reg_addr_t       sb_rd,
  input  reg_addr_t       rs1,
  input  reg_addr_t       rs2,
  output logic            stall,
  output logic            rf_wen,
  output reg_addr_t       rf_rd,
  output logic [XLEN-1:0] rf_din
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       [3:0] starve_cnt;
  logic       [3:0] starve_nxt;
  logic             starve_hit;
  logic             p_xfer;
  logic             m_xfer;
  wb_src_e          src_q;
  reg_addr_t        win_rd;
  logic [XLEN-1:0]  win_data;

  // Each ready depends only on the valids and the counter, never on the other ready.
  assign starve_hit = (starve_cnt == LIMIT);
  assign p_ready    = p_valid && !(m_valid && starve_hit);
  assign m_ready    = m_valid && (!p_valid || starve_hit);
  assign p_xfer     = p_valid && p_ready;
  assign m_xfer     = m_valid && m_ready;

  assign win_rd   = m_xfer ? m_rd   : p_rd;
  assign win_data = m_xfer ? m_data : p_data;

  always_comb begin
    starve_nxt = starve_cnt;
    if (!m_valid || m_xfer) starve_nxt = '0;
    else if (!starve_hit)   starve_nxt = starve_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else        starve_cnt <= starve_nxt;
  end

  // Address and data hold when idle; only the enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen <= 1'b0;
      rf_rd  <= '0;
      rf_din <= '0;
      src_q  <= SRC_P;
    end else if (p_xfer || m_xfer) begin
      rf_wen <= (win_rd != '0);
      rf_rd  <= win_rd;
      rf_din <= win_data;
      src_q  <= m_xfer ? SRC_M : SRC_P;
    end else begin
      rf_wen <= 1'b0;
    end
  end

  rf_scoreboard #(.NREG(NREG)) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .sb_set (sb_set),
    .sb_rd  (sb_rd),
    .clr_en (rf_wen && (src_q == SRC_M)),
    .clr_rd (rf_rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .stall  (stall)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration table plus scoreboard and reset sequences.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_valid, p_ready, m_valid, m_ready;
  logic [4:0]  p_rd, m_rd, sb_rd, rs1, rs2, rf_rd;
  logic [31:0] p_data, m_data, rf_din;
  logic        sb_set, stall, rf_wen;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.XLEN(32), .NREG(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_ready(p_ready), .p_rd(p_rd), .p_data(p_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
    .sb_set(sb_set), .sb_rd(sb_rd), .rs1(rs1), .rs2(rs2), .stall(stall),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_din(rf_din)
  );

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        epr;
    logic        emr;
    logic        ewen;
    logic [4:0]  erd;
    logic [31:0] edin;
  } vec_t;

  localparam int NVEC = 27;
  vec_t tbl [NVEC];

  function automatic vec_t mk(logic pv, logic [4:0] prd, logic [31:0] pd,
                              logic mv, logic [4:0] mrd, logic [31:0] md,
                              logic epr, logic emr, logic ewen,
                              logic [4:0] erd, logic [31:0] edin);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pd = pd; v.mv = mv; v.mrd = mrd; v.md = md;
    v.epr = epr; v.emr = emr; v.ewen = ewen; v.erd = erd; v.edin = edin;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    p_valid = 0; p_rd = 0; p_data = 0;
    m_valid = 0; m_rd = 0; m_data = 0;
    sb_set = 0; sb_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    // Registered rf_* columns reflect the transfer from the previous row.
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,        1, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,        0, 0, 1, 5, 32'hDEADBEEF);
    tbl[2]  = mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 5, 32'hDEADBEEF);
    tbl[3]  = mk(1, 0, 32'h11111111, 0, 0, 0,        1, 0, 0, 5, 32'hDEADBEEF);
    tbl[4]  = mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 32'h11111111);
    tbl[5]  = mk(0, 0, 0,            1, 3, 32'h33,   0, 1, 0, 0, 32'h11111111);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0,        0, 0, 1, 3, 32'h33);
    tbl[7]  = mk(1, 1, 32'h107,      1, 12, 32'hA,   1, 0, 0, 3, 32'h33);
    tbl[8]  = mk(1, 1, 32'h108,      1, 12, 32'hA,   1, 0, 1, 1, 32'h107);
    tbl[9]  = mk(1, 1, 32'h109,      1, 12, 32'hA,   1, 0, 1, 1, 32'h108);
    tbl[10] = mk(1, 1, 32'h10A,      1, 12, 32'hA,   1, 0, 1, 1, 32'h109);
    tbl[11] = mk(1, 1, 32'h10B,      1, 12, 32'hA,   0, 1, 1, 1, 32'h10A);
    tbl[12] = mk(1, 1, 32'h10C,      1, 13, 32'hB,   1, 0, 1, 12, 32'hA);
    tbl[13] = mk(1, 1, 32'h10D,      1, 13, 32'hB,   1, 0, 1, 1, 32'h10C);
    tbl[14] = mk(1, 1, 32'h10E,      1, 13, 32'hB,   1, 0, 1, 1, 32'h10D);
    tbl[15] = mk(1, 1, 32'h10F,      1, 13, 32'hB,   1, 0, 1, 1, 32'h10E);
    tbl[16] = mk(1, 1, 32'h110,      1, 13, 32'hB,   0, 1, 1, 1, 32'h10F);
    tbl[17] = mk(0, 0, 0,            0, 0, 0,        0, 0, 1, 13, 32'hB);
    tbl[18] = mk(1, 1, 32'h200,      1, 14, 32'hC,   1, 0, 0, 13, 32'hB);
    tbl[19] = mk(1, 1, 32'h200,      1, 14, 32'hC,   1, 0, 1, 1, 32'h200);
    tbl[20] = mk(1, 1, 32'h200,      0, 0, 0,        1, 0, 1, 1, 32'h200);
    tbl[21] = mk(1, 1, 32'h200,      1, 14, 32'hC,   1, 0, 1, 1, 32'h200);
    tbl[22] = mk(1, 1, 32'h200,      1, 14, 32'hC,   1, 0, 1, 1, 32'h200);
    tbl[23] = mk(1, 1, 32'h200,      1, 14, 32'hC,   1, 0, 1, 1, 32'h200);
    tbl[24] = mk(1, 1, 32'h200,      1, 14, 32'hC,   1, 0, 1, 1, 32'h200);
    tbl[25] = mk(1, 1, 32'h200,      1, 14, 32'hC,   0, 1, 1, 1, 32'h200);
    tbl[26] = mk(0, 0, 0,            0, 0, 0,        0, 0, 1, 14, 32'hC);

    idle();
    rst_n = 0;
    #3;
    chk("rst_p_ready", {31'd0, p_ready}, 32'd0);
    chk("rst_m_ready", {31'd0, m_ready}, 32'd0);
    chk("rst_stall",   {31'd0, stall},   32'd0);
    chk("rst_rf_wen",  {31'd0, rf_wen},  32'd0);
    chk("rst_rf_rd",   {27'd0, rf_rd},   32'd0);
    chk("rst_rf_din",  rf_din,           32'd0);
    nxt();
    rst_n = 1;

    for (int i = 0; i < NVEC; i++) begin
      p_valid = tbl[i].pv; p_rd = tbl[i].prd; p_data = tbl[i].pd;
      m_valid = tbl[i].mv; m_rd = tbl[i].mrd; m_data = tbl[i].md;
      smp();
      chk($sformatf("v%0d_p_ready", i), {31'd0, p_ready}, {31'd0, tbl[i].epr});
      chk($sformatf("v%0d_m_ready", i), {31'd0, m_ready}, {31'd0, tbl[i].emr});
      chk($sformatf("v%0d_stall", i),   {31'd0, stall},   32'd0);
      chk($sformatf("v%0d_rf_wen", i),  {31'd0, rf_wen},  {31'd0, tbl[i].ewen});
      chk($sformatf("v%0d_rf_rd", i),   {27'd0, rf_rd},   {27'd0, tbl[i].erd});
      chk($sformatf("v%0d_rf_din", i),  rf_din,           tbl[i].edin);
      nxt();
    end
    idle();

    // Scoreboard: set x7, p write to x7 must not clear it, m write clears at t+2.
    sb_set = 1; sb_rd = 7; rs1 = 7;
    smp(); chk("sb_same_cycle_no_stall", {31'd0, stall}, 32'd0);
    nxt(); sb_set = 0;
    smp(); chk("sb_stall_after_set", {31'd0, stall}, 32'd1);
    nxt(); p_valid = 1; p_rd = 7; p_data = 32'h70;
    smp(); chk("sb_p7_ready", {31'd0, p_ready}, 32'd1);
    nxt(); p_valid = 0;
    smp(); chk("sb_p7_wen", {31'd0, rf_wen}, 32'd1);
    chk("sb_p7_stall", {31'd0, stall}, 32'd1);
    nxt();
    smp(); chk("sb_p_write_keeps_pend", {31'd0, stall}, 32'd1);
    nxt(); m_valid = 1; m_rd = 7; m_data = 32'h77;
    smp(); chk("sb_m7_ready", {31'd0, m_ready}, 32'd1);
    chk("sb_m7_stall_t0", {31'd0, stall}, 32'd1);
    nxt(); m_valid = 0;
    smp(); chk("sb_m7_stall_t1", {31'd0, stall}, 32'd1);
    chk("sb_m7_wen_t1", {31'd0, rf_wen}, 32'd1);
    chk("sb_m7_rd_t1", {27'd0, rf_rd}, 32'd7);
    chk("sb_m7_din_t1", rf_din, 32'h77);
    nxt();
    smp(); chk("sb_m7_stall_t2", {31'd0, stall}, 32'd0);
    chk("sb_m7_wen_t2", {31'd0, rf_wen}, 32'd0);
    nxt();

    // x0 is never tracked.
    rs1 = 0; rs2 = 0; sb_set = 1; sb_rd = 0;
    nxt(); sb_set = 0;
    smp(); chk("x0_set_no_stall", {31'd0, stall}, 32'd0);
    nxt();

    // Set and clear of x9 in the same cycle: set wins.
    sb_set = 1; sb_rd = 9; rs2 = 9;
    nxt(); sb_set = 0;
    smp(); chk("x9_pending", {31'd0, stall}, 32'd1);
    nxt(); m_valid = 1; m_rd = 9; m_data = 32'h99;
    smp(); chk("x9_m_ready", {31'd0, m_ready}, 32'd1);
    nxt(); m_valid = 0; sb_set = 1; sb_rd = 9;
    smp(); chk("x9_commit_wen", {31'd0, rf_wen}, 32'd1);
    chk("x9_commit_rd", {27'd0, rf_rd}, 32'd9);
    nxt(); sb_set = 0;
    smp(); chk("x9_set_wins", {31'd0, stall}, 32'd1);
    nxt(); m_valid = 1; m_rd = 9; m_data = 32'h9A;
    nxt(); m_valid = 0;
    nxt();
    smp(); chk("x9_cleared", {31'd0, stall}, 32'd0);
    nxt(); rs2 = 0;

    // Async reset between the transfer edge and the commit edge.
    rs1 = 20; sb_set = 1; sb_rd = 20;
    nxt(); sb_set = 0;
    smp(); chk("ar_pending", {31'd0, stall}, 32'd1);
    nxt(); m_valid = 1; m_rd = 21; m_data = 32'h2121;
    nxt(); m_valid = 0;
    smp(); chk("ar_wen_before", {31'd0, rf_wen}, 32'd1);
    #1 rst_n = 0;
    #1;
    chk("ar_wen_dropped", {31'd0, rf_wen}, 32'd0);
    chk("ar_rd_cleared", {27'd0, rf_rd}, 32'd0);
    chk("ar_pend_cleared", {31'd0, stall}, 32'd0);
    #1 rst_n = 1;
    nxt();
    smp(); chk("ar_after_release_stall", {31'd0, stall}, 32'd0);
    chk("ar_after_release_wen", {31'd0, rf_wen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
